// File: rtl/mem_txn_sequencer.sv
// Write/read-back memory test sequencer: writes an LFSR pattern to a RAM range,
// reads it back, and counts mismatches. All outputs are registered.
module mem_txn_sequencer #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     num_txns,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [7:0]               seed,
  output logic                     read_write,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [7:0]               data,
  output logic                     cs,
  output logic                     oe,
  input  logic [7:0]               rdata,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     err_count,
  output logic                     mismatch
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_e;

  function automatic logic [7:0] pat_step(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     n_q, n_d;
  logic [CNT_WIDTH-1:0]     idx_q, idx_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [7:0]               seed_q, seed_d;
  logic [7:0]               pat_q, pat_d;
  logic [7:0]               exp_q, exp_d;
  logic [7:0]               exp_cmp_q, exp_cmp_d;
  logic                     cmp_vld_q, cmp_vld_d;
  logic                     rw_q, rw_d;
  logic                     cs_q, cs_d;
  logic                     oe_q, oe_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [CNT_WIDTH-1:0]     err_q, err_d;
  logic                     mm_q, mm_d;
  logic [7:0]               seed_n;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    base_d    = base_q;
    seed_d    = seed_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    rw_d      = 1'b0;
    cs_d      = 1'b0;
    oe_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    mm_d      = 1'b0;
    seed_n    = (seed == 8'h00) ? 8'h01 : seed;
    // rdata answers the read that was on the bus last cycle
    cmp_vld_d = cs_q & oe_q;
    exp_cmp_d = exp_q;

    if (cmp_vld_q && (rdata != exp_cmp_q)) begin
      mm_d = 1'b1;
      if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = num_txns;
          base_d = base_addr;
          seed_d = seed_n;
          err_d  = '0;
          if (num_txns != '0) begin
            state_d = WRITE;
            cs_d    = 1'b1;
            rw_d    = 1'b1;
            addr_d  = base_addr;
            data_d  = seed_n;
            pat_d   = pat_step(seed_n);
            idx_d   = CNT_WIDTH'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (idx_q != n_q) begin
          cs_d   = 1'b1;
          rw_d   = 1'b1;
          addr_d = base_q + ADDRESS_WIDTH'(idx_q);
          data_d = pat_q;
          pat_d  = pat_step(pat_q);
          idx_d  = idx_q + CNT_WIDTH'(1);
        end else begin
          // first read issues immediately; pattern restarts from the seed
          state_d = READ;
          cs_d    = 1'b1;
          oe_d    = 1'b1;
          addr_d  = base_q;
          exp_d   = seed_q;
          pat_d   = pat_step(seed_q);
          idx_d   = CNT_WIDTH'(1);
        end
      end
      READ: begin
        if (idx_q != n_q) begin
          cs_d   = 1'b1;
          oe_d   = 1'b1;
          addr_d = base_q + ADDRESS_WIDTH'(idx_q);
          exp_d  = pat_q;
          pat_d  = pat_step(pat_q);
          idx_d  = idx_q + CNT_WIDTH'(1);
        end else begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      seed_q    <= 8'h01;
      pat_q     <= 8'h01;
      exp_q     <= '0;
      exp_cmp_q <= '0;
      cmp_vld_q <= 1'b0;
      rw_q      <= 1'b0;
      cs_q      <= 1'b0;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      mm_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      exp_cmp_q <= exp_cmp_d;
      cmp_vld_q <= cmp_vld_d;
      rw_q      <= rw_d;
      cs_q      <= cs_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      mm_q      <= mm_d;
    end
  end

  assign read_write = rw_q;
  assign cs         = cs_q;
  assign oe         = oe_q;
  assign address    = addr_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_count  = err_q;
  assign mismatch   = mm_q;

endmodule

// File: tb/tb_mem_txn_sequencer.sv
// Directed bench for mem_txn_sequencer with a 1-cycle-latency RAM model and
// an optional single-address read corruption.
module tb_mem_txn_sequencer;
  localparam int AW = 30;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_txns;
  logic [AW-1:0] base_addr;
  logic [7:0]    seed;
  logic          read_write;
  logic [AW-1:0] address;
  logic [7:0]    data;
  logic          cs;
  logic          oe;
  logic [7:0]    rdata = 8'h00;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_count;
  logic          mismatch;

  int checks = 0;
  int errors = 0;

  logic          corrupt = 1'b0;
  logic [AW-1:0] corrupt_addr = 30'h102;
  logic [7:0]    mem [256];

  always #5 clk = ~clk;

  mem_txn_sequencer #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_txns(num_txns),
    .base_addr(base_addr), .seed(seed), .read_write(read_write),
    .address(address), .data(data), .cs(cs), .oe(oe), .rdata(rdata),
    .busy(busy), .done(done), .err_count(err_count), .mismatch(mismatch)
  );

  always @(posedge clk) begin
    if (cs && read_write) mem[address[7:0]] <= data;
    if (cs && !read_write)
      rdata <= (corrupt && address == corrupt_addr) ? 8'hFF : mem[address[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    assert (!(cs === 1'b1 && read_write === 1'b1 && oe === 1'b1)) else begin
      errors++;
      $error("FAIL bus_conflict obs=%0b%0b%0b exp=not 111", cs, read_write, oe);
    end
  end

  task automatic kick(input logic [CW-1:0] n, input logic [AW-1:0] b, input logic [7:0] s);
    @(negedge clk);
    num_txns  = n;
    base_addr = b;
    seed      = s;
    start     = 1'b1;
  endtask

  // N=4 at 0x100, seed 0x01: writes k1-4, reads k5-8, flush k9, DONE k10, done k11
  task automatic basic_run(input logic fault);
    logic [7:0] pat [4];
    pat = '{8'h01, 8'h02, 8'h04, 8'h08};
    kick(16'd4, 30'h100, 8'h01);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k <= 4) begin
        chk($sformatf("basic_wcs_k%0d", k), cs, 1);
        chk($sformatf("basic_wrw_k%0d", k), read_write, 1);
        chk($sformatf("basic_woe_k%0d", k), oe, 0);
        chk($sformatf("basic_waddr_k%0d", k), address, 32'h100 + k - 1);
        chk($sformatf("basic_wdata_k%0d", k), data, pat[k-1]);
      end else if (k <= 8) begin
        chk($sformatf("basic_rcs_k%0d", k), cs, 1);
        chk($sformatf("basic_rrw_k%0d", k), read_write, 0);
        chk($sformatf("basic_roe_k%0d", k), oe, 1);
        chk($sformatf("basic_raddr_k%0d", k), address, 32'h100 + k - 5);
      end else begin
        chk($sformatf("basic_idle_cs_k%0d", k), cs, 0);
        chk($sformatf("basic_idle_oe_k%0d", k), oe, 0);
      end
      chk($sformatf("basic_busy_k%0d", k), busy, (k <= 10) ? 1 : 0);
      chk($sformatf("basic_done_k%0d", k), done, (k == 11) ? 1 : 0);
      chk($sformatf("basic_mm_f%0d_k%0d", fault, k), mismatch, (fault && k == 9) ? 1 : 0);
      if (k == 11) chk($sformatf("basic_err_f%0d", fault), err_count, fault ? 1 : 0);
    end
  endtask

  initial begin
    logic [7:0] wpat [3];
    rst = 1'b1; start = 1'b0; num_txns = '0; base_addr = '0; seed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs, 0);
    chk("rst_oe", oe, 0);
    chk("rst_rw", read_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mm", mismatch, 0);
    chk("rst_err", err_count, 0);
    chk("rst_addr", address, 0);
    chk("rst_data", data, 0);
    rst = 1'b0;

    basic_run(1'b0);
    corrupt = 1'b1;
    basic_run(1'b1);
    corrupt = 1'b0;

    // address wrap, seed 0x5A -> 5A, B4, 69
    wpat = '{8'h5A, 8'hB4, 8'h69};
    kick(16'd3, 30'h3FFFFFFE, 8'h5A);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k <= 3) begin
        chk($sformatf("wrap_waddr_k%0d", k), address, (32'h3FFFFFFE + k - 1) & 32'h3FFFFFFF);
        chk($sformatf("wrap_wdata_k%0d", k), data, wpat[k-1]);
        chk($sformatf("wrap_wrw_k%0d", k), read_write, 1);
      end else if (k <= 6) begin
        chk($sformatf("wrap_raddr_k%0d", k), address, (32'h3FFFFFFE + k - 4) & 32'h3FFFFFFF);
        chk($sformatf("wrap_roe_k%0d", k), oe, 1);
      end
      chk($sformatf("wrap_done_k%0d", k), done, (k == 9) ? 1 : 0);
      if (k == 9) chk("wrap_err", err_count, 0);
    end

    // zero length
    kick(16'd0, 30'h55, 8'h10);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk($sformatf("zero_cs_k%0d", k), cs, 0);
      chk($sformatf("zero_busy_k%0d", k), busy, (k == 1) ? 1 : 0);
      chk($sformatf("zero_done_k%0d", k), done, (k == 2) ? 1 : 0);
    end

    // seed 0 maps to 0x01; a start during WRITE is ignored
    wpat = '{8'h01, 8'h02, 8'h04};
    kick(16'd3, 30'h20, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        chk($sformatf("ign_waddr_k%0d", k), address, 32'h20 + k - 1);
        chk($sformatf("ign_wdata_k%0d", k), data, wpat[k-1]);
      end else if (k <= 6) begin
        chk($sformatf("ign_raddr_k%0d", k), address, 32'h20 + k - 4);
        chk($sformatf("ign_rrw_k%0d", k), read_write, 0);
      end else if (k == 7) begin
        chk("ign_flush_cs", cs, 0);
      end
      chk($sformatf("ign_done_k%0d", k), done, (k == 9) ? 1 : 0);
      chk($sformatf("ign_busy_k%0d", k), busy, (k <= 8) ? 1 : 0);
      if (k == 9) chk("ign_err", err_count, 0);
      if (k == 1) begin
        num_txns = 16'd7; base_addr = 30'h80; seed = 8'h33;
      end
      if (k == 2) start = 1'b0;
    end

    // abort during the 2nd READ cycle; the corrupted first read must not count
    corrupt_addr = 30'h40;
    corrupt = 1'b1;
    kick(16'd4, 30'h40, 8'h01);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 6) begin
        chk("abort_pre_addr", address, 32'h41);
        chk("abort_pre_oe", oe, 1);
        rst = 1'b1;
      end
      if (k == 7) begin
        chk("abort_cs", cs, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err_count, 0);
        chk("abort_mm", mismatch, 0);
        rst = 1'b0;
      end
      if (k >= 7) begin
        chk($sformatf("abort_nodone_k%0d", k), done, 0);
        chk($sformatf("abort_nocs_k%0d", k), cs, 0);
      end
    end
    corrupt = 1'b0;
    basic_run(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_txn_sequencer.md
MEM_TXN_SEQUENCER -- requirements
Module: mem_txn_sequencer

Interface
REQ-001 Parameter: ADDRESS_WIDTH, default 30, width of the memory address bus.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the transaction count and error counter.
REQ-003 Fixed: data width is 8 bits; it is not a parameter.
REQ-004 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  single-cycle request to begin a write/read-back run.
REQ-007 Port: num_txns  input  CNT_WIDTH  number of locations to write and then read.
REQ-008 Port: base_addr  input  ADDRESS_WIDTH  first address of the run.
REQ-009 Port: seed  input  8  initial data-pattern value.
REQ-010 Port: read_write  output  1  1 = write, 0 = read; drives the RAM.
REQ-011 Port: address  output  ADDRESS_WIDTH  RAM address.
REQ-012 Port: data  output  8  write data; valid when cs=1 and read_write=1.
REQ-013 Port: cs  output  1  RAM chip select.
REQ-014 Port: oe  output  1  RAM output enable; asserted only for reads.
REQ-015 Port: rdata  input  8  RAM read data; valid one cycle after a read cycle.
REQ-016 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-017 Port: done  output  1  one-cycle pulse at the end of a run.
REQ-018 Port: err_count  output  CNT_WIDTH  read-back mismatches in the current or last run.
REQ-019 Port: mismatch  output  1  one-cycle pulse on each read-back mismatch.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 FSM states SHALL be IDLE, WRITE, READ, FLUSH and DONE.
REQ-022 IDLE: start=1 SHALL latch num_txns, base_addr and seed, and SHALL clear err_count.
REQ-023 IDLE: on an accepted start, the next state SHALL be WRITE when num_txns != 0, else DONE.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 WRITE: one write per cycle; cs=1, read_write=1, oe=0.
REQ-026 WRITE: address=base_addr+i and data=P(i) for i = 0..num_txns-1.
REQ-027 After the last write, WRITE SHALL go to READ with no idle cycle.
REQ-028 READ: one read per cycle; cs=1, read_write=0, oe=1, address=base_addr+i, same order as WRITE.
REQ-029 READ: the pattern generator SHALL restart from the latched seed.
REQ-030 After the last read, READ SHALL go to FLUSH for exactly one cycle, with cs=0 and oe=0.
REQ-031 Compare: rdata SHALL be compared with P(i) in the cycle after read i is issued (READ cycles 2..N plus FLUSH).
REQ-032 On each compare inequality, mismatch SHALL pulse and err_count SHALL increment.
REQ-033 err_count SHALL saturate at all-ones.
REQ-034 DONE: done=1 for one cycle, then the FSM SHALL return to IDLE.
REQ-035 busy SHALL be 1 in WRITE, READ, FLUSH and DONE, and 0 in IDLE.
REQ-036 Address arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-037 Pattern: P(0)=seed, with seed 0x00 replaced by 0x01.
REQ-038 Pattern step: P(i+1)={P(i)[6:0], P(i)[7]^P(i)[5]^P(i)[4]^P(i)[3]}.
REQ-039 When cs=0, read_write SHALL be 0, oe SHALL be 0, and address and data SHALL hold their last values.
REQ-040 cs and oe SHALL never be 1 together with read_write=1.

Reset
REQ-041 rst=1 at a posedge SHALL force IDLE from any state, including mid-run.
REQ-042 Reset values: cs=0, oe=0, read_write=0, busy=0, done=0, mismatch=0, err_count=0, address=0, data=0.
REQ-043 Reset values for internal registers: latched num_txns=0, latched base_addr=0, pattern register=0x01.
REQ-044 A run aborted by reset SHALL NOT produce a done pulse.

Verification
REQ-045 Basic: ideal 1-cycle-latency RAM model; start with num_txns=4, base_addr=0x100, seed=0x01.
  -> writes 0x100..0x103 with data 01,02,04,08; reads 0x100..0x103; done 11 cycles after start; err_count=0.
REQ-046 Fault: same run, but the RAM model corrupts the read of 0x102 to 0xFF.
  -> exactly one mismatch pulse, in the cycle after the 0x102 read; err_count=1 at done.
REQ-047 Wrap: base_addr=0x3FFFFFFE, num_txns=3.
  -> write addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000, in that order.
REQ-048 Zero length: num_txns=0.
  -> no cs activity; done pulses 2 cycles after start; busy high for 1 cycle.
REQ-049 Abort: rst asserted during the 2nd READ cycle.
  -> next cycle cs=0, busy=0, err_count=0; no done pulse; a new start runs normally.
REQ-050 Ignored start: start asserted during WRITE with different inputs.
  -> the run continues unchanged with the original parameters.
REQ-051 Throughout all scenarios: no cycle with cs=1, read_write=1 and oe=1 together.
